// File: rtl/aes_pkg.sv
// aes_pkg: scheduler state type, default AES geometry and byte-level round helpers.
// State layout: byte 0 in [127:120], column-major (byte r+4c is row r, column c).
package aes_pkg;

    localparam int DEF_WORD = 32;
    localparam int DEF_NB   = 4;
    localparam int DEF_NR   = 10;
    localparam int BLK_W    = DEF_WORD * DEF_NB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[BLK_W-1-8*(row+4*c) -: 8] = s[BLK_W-1-8*(row+4*((c+row)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [7:0]       a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[BLK_W-1-32*c      -: 8];
            a1 = s[BLK_W-1-32*c-8    -: 8];
            a2 = s[BLK_W-1-32*c-16   -: 8];
            a3 = s[BLK_W-1-32*c-24   -: 8];
            r[BLK_W-1-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[BLK_W-1-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[BLK_W-1-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[BLK_W-1-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows -> MixColumns (bypassed on the last round) -> AddRoundKey.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning scheduler qualifies the result with its own handshake.
module aes_round_tail
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] sb_block,
    input  logic [BLK_W-1:0] rk,
    input  logic             last_round,
    output logic [BLK_W-1:0] nxt
);

    logic [BLK_W-1:0] sr;

    assign sr  = shift_rows(sb_block);
    assign nxt = (last_round ? sr : mix_columns(sr)) ^ rk;

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: iterative AES encryption scheduler driving one shared external SUBBYTES per round.
// Latency: o_valid 2*NR+1 cycles after accept with a 1-cycle SUBBYTES; each extra S-box cycle adds one per round.
// Backpressure: one block in flight, o_ready low until ciphertext is taken; AES_ROUND_SCHED_WDOG_EN adds a WAIT watchdog and sticky o_err.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int WORD = DEF_WORD,
    parameter int NB   = DEF_NB,
    parameter int NR   = DEF_NR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WORD*NB-1:0] i_block,
    output logic [3:0]         o_rk_idx,
    input  logic [WORD*NB-1:0] i_rk,
    output logic               o_sb_valid,
    output logic [WORD*NB-1:0] o_sb_block,
    input  logic               i_sb_valid,
    input  logic [WORD*NB-1:0] i_sb_block,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WORD*NB-1:0] o_block,
`ifdef AES_ROUND_SCHED_WDOG_EN
    output logic               o_err,
`endif
    output logic               o_busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    sched_state_t      state_q;
    logic [3:0]        round_q;
    logic [WORD*NB-1:0] blk_q;
    logic [WORD*NB-1:0] tail_nxt;

`ifdef AES_ROUND_SCHED_WDOG_EN
    logic [3:0] wd_q;
    logic       err_q;
    assign o_err = err_q;
`endif

    aes_round_tail u_tail (
        .sb_block   (i_sb_block),
        .rk         (i_rk),
        .last_round (round_q == LAST_RND),
        .nxt        (tail_nxt)
    );

    // Every output decodes from registered state only.
    assign o_ready    = (state_q == IDLE);
    assign o_busy     = (state_q != IDLE);
    assign o_sb_valid = (state_q == ISSUE);
    assign o_sb_block = blk_q;
    assign o_rk_idx   = (state_q == WAIT) ? round_q : 4'd0;
    assign o_valid    = (state_q == DONE);
    assign o_block    = (state_q == DONE) ? blk_q : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            blk_q   <= '0;
`ifdef AES_ROUND_SCHED_WDOG_EN
            wd_q    <= 4'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        blk_q   <= i_block ^ i_rk;
                        round_q <= 4'd1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef AES_ROUND_SCHED_WDOG_EN
                    wd_q    <= 4'd0;
`endif
                end
                WAIT: begin
                    if (i_sb_valid) begin
                        blk_q <= tail_nxt;
                        if (round_q == LAST_RND) begin
                            state_q <= DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state_q <= ISSUE;
                        end
                    end
`ifdef AES_ROUND_SCHED_WDOG_EN
                    // Fifteenth silent WAIT cycle: abandon the block.
                    else if (wd_q == 4'd14) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 4'd1;
                    end
`endif
                end
                DONE: begin
                    if (i_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: behavioural AES model, stalling S-box responder, directed and random blocks.
module tb_aes_round_sched;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid, o_ready, i_ready, o_valid, o_busy;
    logic [127:0] i_block, i_rk, o_sb_block, i_sb_block, o_block;
    logic [3:0]   o_rk_idx;
    logic         o_sb_valid, i_sb_valid;
`ifdef AES_ROUND_SCHED_WDOG_EN
    logic         o_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] rk_tab [0:10];

    bit           sb_on, spur, sb_pend;
    int           sb_delay, sb_cnt;
    logic [127:0] sb_res;

    logic [3:0]   rk_seen[$];
    int           sb_cycles, sb_rises;
    logic         sb_prev = 1'b0;
    int           lat;
    logic [127:0] pt;

    always #5 clk = ~clk;

    aes_round_sched dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_block    (i_block),
        .o_rk_idx   (o_rk_idx),
        .i_rk       (i_rk),
        .o_sb_valid (o_sb_valid),
        .o_sb_block (o_sb_block),
        .i_sb_valid (i_sb_valid),
        .i_sb_block (i_sb_block),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_block    (o_block),
`ifdef AES_ROUND_SCHED_WDOG_EN
        .o_err      (o_err),
`endif
        .o_busy     (o_busy)
    );

    // Key store answers in the same cycle.
    assign i_rk = (o_rk_idx <= 4'd10) ? rk_tab[o_rk_idx] : '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (v^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk_tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = p ^ rk_tab[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ rk_tab[r];
        end
        return v;
    endfunction

    // External SUBBYTES: answers sb_delay cycles late; optional garbage pulses in IDLE/ISSUE.
    always @(posedge clk) begin
        #1;
        i_sb_valid = 1'b0;
        if (sb_pend) begin
            if (sb_cnt == 0) begin
                i_sb_valid = 1'b1;
                i_sb_block = sb_res;
                sb_pend    = 1'b0;
            end else begin
                sb_cnt--;
            end
        end
        if (sb_on && o_sb_valid) begin
            sb_pend = 1'b1;
            sb_cnt  = sb_delay;
            for (int i = 0; i < 16; i++) sb_res[127-8*i -: 8] = sb_tab[o_sb_block[127-8*i -: 8]];
        end
        if (spur && (o_sb_valid || o_ready)) begin
            i_sb_valid = 1'b1;
            i_sb_block = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Observe the key index at every state update and the S-box issue pulses.
    always @(negedge clk) begin
        if (o_ready && i_valid) rk_seen.push_back(o_rk_idx);
        if (o_busy && !o_sb_valid && !o_valid && i_sb_valid) rk_seen.push_back(o_rk_idx);
        if (o_sb_valid) sb_cycles++;
        if (o_sb_valid && !sb_prev) sb_rises++;
        sb_prev = o_sb_valid;
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept at cycle t; lat is the cycle offset at which o_valid is first seen (bounded).
    task automatic send_block(input logic [127:0] p, input int budget, output int l);
        @(posedge clk); #1;
        rk_seen.delete();
        sb_cycles = 0;
        sb_rises  = 0;
        i_block   = p;
        i_valid   = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_block = {$urandom, $urandom, $urandom, $urandom};
        l = 1;
        @(negedge clk);
        while (!o_valid && l < budget) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic release_out();
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_block = '0;
        i_sb_valid = 1'b0; i_sb_block = '0;
        sb_on = 1'b1; spur = 1'b0; sb_pend = 1'b0; sb_delay = 0; sb_cnt = 0; sb_res = '0;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox(8'(i));
        key_expand(KEY_C1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_b("rst_ready", o_ready, 1'b1);
        chk_b("rst_valid", o_valid, 1'b0);
        chk_b("rst_sb_valid", o_sb_valid, 1'b0);
        chk_w("rst_block", o_block, '0);
        chk_b("rst_busy", o_busy, 1'b0);
`ifdef AES_ROUND_SCHED_WDOG_EN
        chk_b("rst_err", o_err, 1'b0);
`endif

        // FIPS-197 C.1 with a 1-cycle S-box.
        send_block(PT_C1, 80, lat);
        chk_i("c1_latency", lat, 21);
        chk_w("c1_block", o_block, CT_C1);
        chk_i("c1_rk_count", rk_seen.size(), 11);
        for (int i = 0; i < 11; i++)
            chk_i("c1_rk_idx", (i < rk_seen.size()) ? int'(rk_seen[i]) : -1, i);
        chk_i("c1_sb_cycles", sb_cycles, 10);
        chk_i("c1_sb_pulses", sb_rises, 10);

        // Downstream stalls 10 cycles while a new block is offered.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1;
            i_block = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk_b("bp_valid", o_valid, 1'b1);
            chk_w("bp_block", o_block, CT_C1);
            chk_b("bp_ready", o_ready, 1'b0);
        end
        release_out();
        @(negedge clk);
        chk_b("hs_ready", o_ready, 1'b1);
        chk_b("hs_valid", o_valid, 1'b0);
        chk_w("hs_block", o_block, '0);
        chk_b("hs_busy", o_busy, 1'b0);

        // Stalled S-box with spurious result pulses outside WAIT.
        sb_delay = 3;
        spur     = 1'b1;
        send_block(PT_C1, 120, lat);
        chk_i("stall_latency", lat, 51);
        chk_w("stall_block", o_block, CT_C1);
        chk_i("stall_sb_pulses", sb_rises, 10);
        release_out();
        spur = 1'b0;

        // Random keys, plaintexts and S-box delays.
        for (int n = 0; n < 6; n++) begin
            key_expand({$urandom, $urandom, $urandom, $urandom});
            pt       = {$urandom, $urandom, $urandom, $urandom};
            sb_delay = $urandom_range(0, 3);
            send_block(pt, 150, lat);
            chk_i("rand_latency", lat, 1 + 10 * (2 + sb_delay));
            chk_w("rand_block", o_block, aes_ref(pt));
            chk_i("rand_sb_pulses", sb_rises, 10);
            release_out();
        end

        // Reset during round 5.
        key_expand(KEY_C1);
        sb_delay = 0;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_block = PT_C1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_b("mid_busy", o_busy, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_b("mid_rst_valid", o_valid, 1'b0);
        chk_b("mid_rst_busy", o_busy, 1'b0);
        chk_b("mid_rst_ready", o_ready, 1'b1);
        repeat (3) @(posedge clk);
        send_block(PT_C1, 80, lat);
        chk_i("post_rst_latency", lat, 21);
        chk_w("post_rst_block", o_block, CT_C1);
        release_out();

`ifdef AES_ROUND_SCHED_WDOG_EN
        // S-box never answers: watchdog drops the block.
        sb_on = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_block = PT_C1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!o_err && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_i("wd_latency", lat, 17);
        chk_b("wd_busy", o_busy, 1'b0);
        chk_b("wd_ready", o_ready, 1'b1);
        repeat (5) @(negedge clk);
        chk_b("wd_sticky", o_err, 1'b1);
        chk_b("wd_no_valid", o_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_b("wd_clear", o_err, 1'b0);
        sb_on = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
